// File: rtl/mdu_sequencer_if.sv
// Purpose: request/response bundle between the execute stage and the multiply/divide sequencer.
// Latency: none (wires only).
// Backpressure: busy from the sequencer is the only flow control; start is ignored while busy.
// Ports: start/op/a/b/flush driven by the master, busy/done/result driven by the slave.
interface mdu_sequencer_if #(
    parameter int XLEN = 64
);
    logic            start;
    logic [3:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (output start, op, a, b, flush, input busy, done, result);
    modport slave  (input start, op, a, b, flush, output busy, done, result);
endinterface

// File: rtl/mdu_sequencer.sv
// Purpose: iterative RV64M multiply (radix-2 shift-add) / restoring divide controller.
// Latency: done at t+N+2 (N=64, or 32 for W-ops); divide-by-zero/overflow done at t+1.
// Backpressure: busy while not idle; start is ignored until idle, flush aborts.
// Ports: clk, reset (async, active high), mdu (slave modport: start/op/a/b/flush in,
//        busy/done/result out).
module mdu_sequencer #(
    parameter int XLEN = 64
) (
    input  logic          clk,
    input  logic          reset,
    mdu_sequencer_if.slave mdu
);
    localparam int HW = XLEN / 2;
    localparam int CW = $clog2(XLEN + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MUL   = 4'd1;
    localparam logic [3:0] OP_MULW  = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_REM   = 4'd5;
    localparam logic [3:0] OP_REMU  = 4'd6;
    localparam logic [3:0] OP_DIVW  = 4'd7;
    localparam logic [3:0] OP_DIVUW = 4'd8;
    localparam logic [3:0] OP_REMW  = 4'd9;
    localparam logic [3:0] OP_REMUW = 4'd10;

    // Most negative dividend: full width, and the W-op value after sign extension.
    localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_W = {{(HW+1){1'b1}}, {(HW-1){1'b0}}};

    function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] v);
        return {{HW{v[HW-1]}}, v[HW-1:0]};
    endfunction

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] a_q, a_d;        // multiplicand, or dividend/quotient shift register
    logic [XLEN-1:0] b_q, b_d;        // multiplier, or divisor
    logic [XLEN-1:0] acc_q, acc_d;    // product, or partial remainder
    logic            negq_q, negq_d, negr_q, negr_d;
    logic            mul_q, mul_d, w_q, w_d, rem_q, rem_d;
    logic [XLEN-1:0] result_q, result_d;

    // Decode of the incoming op.
    logic op_vld, op_mul, op_w, op_sgn, op_rem, op_zx;
    always_comb begin
        op_vld = 1'b1;
        op_mul = 1'b0;
        op_w   = 1'b0;
        op_sgn = 1'b0;
        op_rem = 1'b0;
        op_zx  = 1'b0;
        case (mdu.op)
            OP_MUL:   op_mul = 1'b1;
            OP_MULW:  begin op_mul = 1'b1; op_w = 1'b1; end
            OP_DIV:   op_sgn = 1'b1;
            OP_DIVU:  ;
            OP_REM:   begin op_sgn = 1'b1; op_rem = 1'b1; end
            OP_REMU:  op_rem = 1'b1;
            OP_DIVW:  begin op_w = 1'b1; op_sgn = 1'b1; end
            OP_DIVUW: begin op_w = 1'b1; op_zx = 1'b1; end
            OP_REMW:  begin op_w = 1'b1; op_sgn = 1'b1; op_rem = 1'b1; end
            OP_REMUW: begin op_w = 1'b1; op_zx = 1'b1; op_rem = 1'b1; end
            default:  op_vld = 1'b0;   // MDU_NOP and unused codes
        endcase
    end

    // Operand preparation and special-case detection at accept.
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, a_load, spec_val;
    logic            sa, sb, div0, ovf, special, accept;
    always_comb begin
        a_ext = mdu.a;
        b_ext = mdu.b;
        if (op_w) begin
            a_ext = op_zx ? {{HW{1'b0}}, mdu.a[HW-1:0]} : sext_w(mdu.a);
            b_ext = op_zx ? {{HW{1'b0}}, mdu.b[HW-1:0]} : sext_w(mdu.b);
        end
        sa     = op_sgn & a_ext[XLEN-1];
        sb     = op_sgn & b_ext[XLEN-1];
        a_mag  = sa ? -a_ext : a_ext;
        b_mag  = sb ? -b_ext : b_ext;
        // Left-align a W dividend so the divide loop always consumes bit XLEN-1.
        a_load = (op_w && !op_mul) ? (a_mag << HW) : a_mag;
        div0   = !op_mul && (b_ext == '0);
        ovf    = op_sgn && (b_ext == '1) && (a_ext == (op_w ? MIN_W : MIN_D));
        special = div0 || ovf;
        if (div0) spec_val = op_rem ? a_ext : '1;
        else      spec_val = op_rem ? '0 : a_ext;
        if (op_w) spec_val = sext_w(spec_val);
        accept = (state_q == S_IDLE) && mdu.start && op_vld && !mdu.flush;
    end

    // Iteration datapath and final fix-up.
    logic [XLEN:0]   rem_sh, trial;
    logic [XLEN-1:0] sel, fix_val;
    always_comb begin
        rem_sh  = {acc_q, a_q[XLEN-1]};
        trial   = rem_sh - {1'b0, b_q};
        if (mul_q)      sel = acc_q;
        else if (rem_q) sel = negr_q ? -acc_q : acc_q;
        else            sel = negq_q ? -a_q : a_q;
        fix_val = w_q ? sext_w(sel) : sel;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        mul_d    = mul_q;
        w_d      = w_q;
        rem_d    = rem_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_d    = a_load;
                    b_d    = b_mag;
                    acc_d  = '0;
                    negq_d = sa ^ sb;
                    negr_d = sa;
                    mul_d  = op_mul;
                    w_d    = op_w;
                    rem_d  = op_rem;
                    cnt_d  = op_w ? CW'(HW) : CW'(XLEN);
                    if (special) begin
                        state_d  = S_DONE;
                        result_d = spec_val;
                    end else begin
                        state_d  = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (mdu.flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (mul_q) begin
                        acc_d = acc_q + (b_q[0] ? a_q : '0);
                        a_d   = a_q << 1;
                        b_d   = b_q >> 1;
                    end else if (!trial[XLEN]) begin
                        acc_d = trial[XLEN-1:0];
                        a_d   = {a_q[XLEN-2:0], 1'b1};
                    end else begin
                        acc_d = rem_sh[XLEN-1:0];
                        a_d   = {a_q[XLEN-2:0], 1'b0};
                    end
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (mdu.flush) begin
                    state_d = S_IDLE;
                end else begin
                    result_d = fix_val;
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_IDLE;   // S_DONE: pulse lasts one cycle, flush or not
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            mul_q    <= 1'b0;
            w_q      <= 1'b0;
            rem_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            mul_q    <= mul_d;
            w_q      <= w_d;
            rem_q    <= rem_d;
            result_q <= result_d;
        end
    end

    assign mdu.busy   = (state_q != S_IDLE);
    assign mdu.done   = (state_q == S_DONE);
    assign mdu.result = result_q;
endmodule

// File: tb/tb_mdu_sequencer.sv
module tb_mdu_sequencer;
    localparam logic [3:0] MUL = 4'd1, MULW = 4'd2, DIV = 4'd3, DIVU = 4'd4, REM = 4'd5,
                           REMU = 4'd6, DIVW = 4'd7, DIVUW = 4'd8, REMW = 4'd9, REMUW = 4'd10;
    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    mdu_sequencer_if #(.XLEN(64)) mif ();
    mdu_sequencer #(.XLEN(64)) dut (.clk(clk), .reset(reset), .mdu(mif.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sx(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Reference results straight from the RV64M arithmetic rules.
    function automatic logic [63:0] ref_res(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [31:0] a32, b32, p32;
        logic [63:0] r;
        logic        ovf64, ovf32;
        a32   = a[31:0];
        b32   = b[31:0];
        ovf64 = (a == MIN64) && (b == ONES);
        ovf32 = (a32 == 32'h8000_0000) && (b32 == 32'hFFFF_FFFF);
        r     = '0;
        case (op)
            MUL:   r = a * b;
            MULW:  begin p32 = a32 * b32; r = sx(p32); end
            DIV:   r = (b == 0) ? ONES : ovf64 ? a : 64'($signed(a) / $signed(b));
            DIVU:  r = (b == 0) ? ONES : a / b;
            REM:   r = (b == 0) ? a : ovf64 ? 64'd0 : 64'($signed(a) % $signed(b));
            REMU:  r = (b == 0) ? a : a % b;
            DIVW:  r = (b32 == 0) ? ONES : ovf32 ? sx(a32) : sx(32'($signed(a32) / $signed(b32)));
            DIVUW: r = (b32 == 0) ? ONES : sx(a32 / b32);
            REMW:  r = (b32 == 0) ? sx(a32) : ovf32 ? 64'd0 : sx(32'($signed(a32) % $signed(b32)));
            REMUW: r = (b32 == 0) ? sx(a32) : sx(a32 % b32);
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        bit w, sgn, bz, ovf;
        w   = (op == MULW) || (op >= DIVW);
        sgn = (op == DIV) || (op == REM) || (op == DIVW) || (op == REMW);
        if (op == MUL || op == MULW) return w ? 34 : 66;
        bz  = w ? (b[31:0] == 0) : (b == 0);
        ovf = sgn && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                        : (a == MIN64 && b == ONES));
        return (bz || ovf) ? 1 : (w ? 34 : 66);
    endfunction

    // One operation: accept edge ends cycle t; k counts cycles after it.
    task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp_r, input int exp_l,
                          input bit poke, input bit fl_done, input string tag);
        int k;
        bit seen, busy_ok;
        @(negedge clk);
        mif.start = 1'b1; mif.op = op; mif.a = a; mif.b = b;
        @(negedge clk);
        mif.start = 1'b0;
        k = 1; seen = 0; busy_ok = 1;
        while (k <= 200 && !seen) begin
            if (mif.busy !== 1'b1) busy_ok = 0;
            if (mif.done === 1'b1) begin
                seen = 1;
            end else begin
                if (poke && k == 5) begin
                    mif.start = 1'b1;
                    mif.op    = 4'($urandom_range(1, 10));
                    mif.a     = {$urandom, $urandom};
                    mif.b     = {$urandom, $urandom};
                end else begin
                    mif.start = 1'b0;
                end
                @(negedge clk);
                k++;
            end
        end
        mif.start = 1'b0;
        check({tag, " latency"}, 64'(k), 64'(exp_l));
        check({tag, " busy"}, 64'(busy_ok), 64'd1);
        check({tag, " result"}, mif.result, exp_r);
        if (fl_done) begin
            mif.flush = 1'b1;
            #1;
            check({tag, " done under flush"}, 64'(mif.done), 64'd1);
        end
        @(negedge clk);
        mif.flush = 1'b0;
        check({tag, " idle after done"}, {62'd0, mif.busy, mif.done}, 64'd0);
    endtask

    initial begin
        logic [63:0] prev, ra, rb;
        logic [3:0]  rop;
        bit          seen_done, idle_ok;
        reset = 1'b1;
        mif.start = 1'b0; mif.op = 4'd0; mif.a = '0; mif.b = '0; mif.flush = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy", 64'(mif.busy), 64'd0);
        check("reset done", 64'(mif.done), 64'd0);
        check("reset result", mif.result, 64'd0);
        reset = 1'b0;

        run_op(MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66, 0, 0, "mul");
        run_op(DIV, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66, 0, 0, "div neg");
        run_op(REM, -64'sd7, 64'd2, ONES, 66, 0, 0, "rem neg");
        run_op(DIVU, 64'd5, 64'd0, ONES, 1, 0, 0, "divu by0");
        run_op(REMU, 64'd5, 64'd0, 64'd5, 1, 0, 0, "remu by0");
        run_op(DIV, MIN64, ONES, MIN64, 1, 0, 0, "div ovf");
        run_op(REM, MIN64, ONES, 64'd0, 1, 0, 0, "rem ovf");
        run_op(MULW, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 34, 0, 0, "mulw");
        run_op(DIVUW, 64'hFFFF_FFFF, 64'd1, ONES, 34, 0, 0, "divuw");
        run_op(REMUW, 64'h1234_5678_8000_0005, 64'hABCD_0000_0000_0000, 64'hFFFF_FFFF_8000_0005, 1, 0, 0, "remuw by0");
        run_op(DIVW, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 0, 0, "divw ovf");

        // Flush mid-divide, with a stray start while busy.
        prev = mif.result;
        @(negedge clk);
        mif.start = 1'b1; mif.op = DIV; mif.a = 64'd1000; mif.b = 64'd7;
        @(negedge clk);
        seen_done = 0;
        for (int k = 1; k <= 10; k++) begin
            mif.start = (k == 5);
            mif.op    = (k == 5) ? MUL : DIV;
            mif.flush = (k == 10);
            if (mif.done === 1'b1) seen_done = 1;
            @(negedge clk);
        end
        mif.start = 1'b0; mif.flush = 1'b0;
        check("flush busy drop", 64'(mif.busy), 64'd0);
        idle_ok = 1;
        for (int k = 0; k < 4; k++) begin
            if (mif.busy !== 1'b0 || mif.done !== 1'b0) idle_ok = 0;
            if (mif.done === 1'b1) seen_done = 1;
            @(negedge clk);
        end
        check("flush no done", 64'(seen_done), 64'd0);
        check("flush stays idle", 64'(idle_ok), 64'd1);
        check("flush result kept", mif.result, prev);
        run_op(MUL, 64'd3, 64'd4, 64'd12, 66, 0, 0, "mul after flush");

        // Flush in IDLE wins over start.
        mif.start = 1'b1; mif.flush = 1'b1; mif.op = MUL; mif.a = 64'd9; mif.b = 64'd9;
        @(negedge clk);
        mif.start = 1'b0; mif.flush = 1'b0;
        check("idle flush blocks", 64'(mif.busy), 64'd0);

        // Start while busy and flush on the done cycle.
        run_op(DIVU, 64'd100, 64'd7, 64'd14, 66, 1, 0, "divu poked");
        run_op(MULW, 64'd6, 64'd7, 64'd42, 34, 0, 1, "mulw flush@done");

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        mif.start = 1'b1; mif.op = DIV; mif.a = 64'd77; mif.b = 64'd5;
        @(negedge clk);
        mif.start = 1'b0;
        repeat (8) @(negedge clk);
        check("busy before reset", 64'(mif.busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("async rst busy", 64'(mif.busy), 64'd0);
        check("async rst done", 64'(mif.done), 64'd0);
        check("async rst result", mif.result, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Randomized operations against the reference model.
        for (int i = 0; i < 30; i++) begin
            rop = 4'($urandom_range(1, 10));
            case ($urandom_range(0, 5))
                0: ra = MIN64;
                1: ra = {$urandom, 32'h8000_0000};
                default: ra = {$urandom, $urandom};
            endcase
            case ($urandom_range(0, 5))
                0: rb = {$urandom, 32'h0};
                1: rb = ONES;
                2: rb = 64'($urandom_range(1, 9));
                default: rb = {$urandom, $urandom};
            endcase
            run_op(rop, ra, rb, ref_res(rop, ra, rb), ref_lat(rop, ra, rb),
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                   $sformatf("rand%0d op%0d", i, rop));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
